// File: rtl/det_frame_arbiter_if.sv
// Bundle of the requester and detector signals around det_frame_arbiter.
// Handshake: a requester holds ReqN (and DataN stable) until it sees the
// one-cycle GntN pulse. DataN is captured on the grant edge. Busy stays high
// from the grant cycle through the Done cycle. Done is a one-cycle pulse
// during which Count/Owner describe the finished frame.
interface det_frame_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             Req0;
  logic             Req1;
  logic [WIDTH-1:0] Data0;
  logic [WIDTH-1:0] Data1;
  logic             Gnt0;
  logic             Gnt1;
  logic             Sin;
  logic             DetRst;
  logic             Det;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Count;
  logic             Owner;

  // Requester/detector side: drives requests, words and the detector output.
  modport master (
    output Req0, Req1, Data0, Data1, Det,
    input  Gnt0, Gnt1, Sin, DetRst, Busy, Done, Count, Owner
  );

  // Arbiter side.
  modport slave (
    input  Req0, Req1, Data0, Data1, Det,
    output Gnt0, Gnt1, Sin, DetRst, Busy, Done, Count, Owner
  );
endinterface

// File: rtl/det_frame_arbiter.sv
// det_frame_arbiter: shares one serial Mealy detector between two requesters.
// The granted word is shifted MSB-first onto Sin and detector matches are
// counted per bit. The detector is held in reset for the CLEAR cycle of every
// frame so no state leaks between frames.
// Optional feature macro: ROUND_ROBIN_EN (tie goes to the requester that did
// not own the previous frame). Without it, Req0 has fixed priority.
// dbg_state exposes the FSM state for checkers.
module det_frame_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  det_frame_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             owner_q, owner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             sin_q, sin_d;
  logic             detrst_q, detrst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             win;

`ifdef ROUND_ROBIN_EN
  // prio_q names the requester that wins a tie; 0 after reset.
  logic prio_q, prio_d;

  // Tie-break by pointer, lone requester always wins.
  always_comb begin
    win = bus.Req1 & (~bus.Req0 | prio_q);
  end
`else
  // Fixed priority: Req0 beats Req1.
  always_comb begin
    win = bus.Req1 & ~bus.Req0;
  end
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    count_d  = count_q;
    owner_d  = owner_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    sin_d    = 1'b0;
    detrst_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef ROUND_ROBIN_EN
    prio_d   = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          state_d  = CLEAR;
          owner_d  = win;
          sr_d     = win ? bus.Data1 : bus.Data0;
          gnt0_d   = ~win;
          gnt1_d   = win;
          detrst_d = 1'b0;
          busy_d   = 1'b1;
          count_d  = '0;
          bit_d    = '0;
`ifdef ROUND_ROBIN_EN
          prio_d   = ~win;
`endif
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        sin_d   = sr_q[WIDTH-1];
        sr_d    = {sr_q[WIDTH-2:0], 1'b0};
        busy_d  = 1'b1;
      end
      SHIFT: begin
        busy_d = 1'b1;
        // Det reflects the bit currently on Sin.
        if (bus.Det && (count_q != CNT_MAX)) begin
          count_d = count_q + 1'b1;
        end
        if (bit_q == LAST_BIT) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          sin_d = sr_q[WIDTH-1];
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      bit_q    <= '0;
      count_q  <= '0;
      owner_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      sin_q    <= 1'b0;
      detrst_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
      prio_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      count_q  <= count_d;
      owner_q  <= owner_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      sin_q    <= sin_d;
      detrst_q <= detrst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ROUND_ROBIN_EN
      prio_q   <= prio_d;
`endif
    end
  end

  assign bus.Gnt0   = gnt0_q;
  assign bus.Gnt1   = gnt1_q;
  assign bus.Sin    = sin_q;
  assign bus.DetRst = detrst_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Count  = count_q;
  assign bus.Owner  = owner_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_det_frame_arbiter.sv
// Bench for det_frame_arbiter with a Mealy "11" detector model.
module tb_det_frame_arbiter;

  localparam int W = 8;
  localparam int C = 4;

  logic       Clk;
  logic       Reset;
  logic [1:0] dbg_state;
  logic       prev_sin;

  det_frame_arbiter_if #(.WIDTH(W), .CNT_W(C)) bus ();

  det_frame_arbiter #(.WIDTH(W), .CNT_W(C)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Detector model: Det = previous Sin & current Sin, cleared by DetRst low.
  always_ff @(posedge Clk or negedge bus.DetRst) begin
    if (!bus.DetRst) prev_sin <= 1'b0;
    else             prev_sin <= bus.Sin;
  end
  assign bus.Det = prev_sin & bus.Sin;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic         gnt_q[$];
  logic [W-1:0] data_q[$];
  logic [C:0]   exp_q[$];   // {owner, count}

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  int           phase = 0;
  logic [W-1:0] word  = '0;
  logic         prev_done = 1'b0;

  always @(negedge Clk) begin
    logic [C:0] e;
    logic       g;
    if (!Reset) begin
      phase     = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.Gnt0 || bus.Gnt1) begin
        g = bus.Gnt1;
        chk("gnt_onehot", int'(bus.Gnt0 & bus.Gnt1), 0);
        chk("gnt_gap_after_done", int'(prev_done), 0);
        chk("gnt_while_busy", phase, 0);
        chk("clear_detrst", int'(bus.DetRst), 0);
        chk("clear_busy", int'(bus.Busy), 1);
        chk("clear_sin", int'(bus.Sin), 0);
        chk("clear_count", int'(bus.Count), 0);
        chk("clear_owner", int'(bus.Owner), int'(g));
        if (gnt_q.size() == 0) fail_now("gnt_unexpected");
        else chk("gnt_order", int'(g), int'(gnt_q.pop_front()));
        word  = (data_q.size() != 0) ? data_q.pop_front() : '0;
        phase = 1;
      end else if (phase >= 1 && phase <= W) begin
        chk("sin_bit", int'(bus.Sin), int'(word[W-phase]));
        chk("shift_busy", int'(bus.Busy), 1);
        chk("shift_detrst", int'(bus.DetRst), 1);
        chk("shift_no_done", int'(bus.Done), 0);
        phase++;
      end else if (phase == W + 1) begin
        chk("done_latency", int'(bus.Done), 1);
        chk("done_busy", int'(bus.Busy), 1);
        phase = 0;
      end else if (bus.Done) begin
        fail_now("done_timing");
      end
      if (bus.Done) begin
        chk("done_sin", int'(bus.Sin), 0);
        if (exp_q.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("done_count", int'(bus.Count), int'(e[C-1:0]));
          chk("done_owner", int'(bus.Owner), int'(e[C]));
        end
      end
      prev_done = bus.Done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic idx, input logic [W-1:0] d, input int cnt, input bit done_exp);
    gnt_q.push_back(idx);
    data_q.push_back(d);
    if (done_exp) exp_q.push_back({idx, C'(cnt)});
  endtask

  task automatic wait_gnt(input logic idx);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (idx ? bus.Gnt1 : bus.Gnt0) seen = 1'b1;
    end
    if (!seen) fail_now("gnt_timeout");
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (bus.Done) seen = 1'b1;
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic send(input logic idx, input logic [W-1:0] d, input int cnt);
    push_exp(idx, d, cnt, 1'b1);
    if (idx) begin bus.Req1 = 1'b1; bus.Data1 = d; end
    else     begin bus.Req0 = 1'b1; bus.Data0 = d; end
    wait_gnt(idx);
    if (idx) bus.Req1 = 1'b0; else bus.Req0 = 1'b0;
    wait_done();
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset     = 1'b0;
    bus.Req0  = 1'b0;
    bus.Req1  = 1'b0;
    bus.Data0 = '0;
    bus.Data1 = '0;

    repeat (2) @(negedge Clk);
    chk("rst_gnt0", int'(bus.Gnt0), 0);
    chk("rst_gnt1", int'(bus.Gnt1), 0);
    chk("rst_sin", int'(bus.Sin), 0);
    chk("rst_detrst", int'(bus.DetRst), 0);
    chk("rst_busy", int'(bus.Busy), 0);
    chk("rst_done", int'(bus.Done), 0);
    chk("rst_count", int'(bus.Count), 0);
    chk("rst_owner", int'(bus.Owner), 0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle_detrst", int'(bus.DetRst), 1);
    chk("idle_busy", int'(bus.Busy), 0);

    // Basic frame: 0110_1110 holds three "11" pairs.
    send(1'b0, 8'b0110_1110, 3);

    // Back-to-back frames; detector cleared between frames.
    send(1'b0, 8'h01, 0);
    send(1'b1, 8'h80, 0);
    send(1'b1, 8'hFF, 7);
    repeat (2) @(negedge Clk);
    chk("idle_count_hold", int'(bus.Count), 7);
    chk("idle_owner_hold", int'(bus.Owner), 1);
    chk("idle_busy_low", int'(bus.Busy), 0);

    // Reset in the 4th SHIFT cycle abandons the frame.
    push_exp(1'b0, 8'hFF, 0, 1'b0);
    bus.Req0  = 1'b1;
    bus.Data0 = 8'hFF;
    wait_gnt(1'b0);
    bus.Req0 = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("abort_sin", int'(bus.Sin), 0);
    chk("abort_detrst", int'(bus.DetRst), 0);
    chk("abort_busy", int'(bus.Busy), 0);
    chk("abort_count", int'(bus.Count), 0);
    chk("abort_done", int'(bus.Done), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    send(1'b1, 8'hC0, 1);

    // Both requesters held continuously from a fresh reset.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef ROUND_ROBIN_EN
      if (i % 2 == 1) push_exp(1'b1, 8'h33, 2, 1'b1);
      else            push_exp(1'b0, 8'h0F, 3, 1'b1);
`else
      push_exp(1'b0, 8'h0F, 3, 1'b1);
`endif
    end
    bus.Data0 = 8'h0F;
    bus.Data1 = 8'h33;
    bus.Req0  = 1'b1;
    bus.Req1  = 1'b1;
    for (int i = 0; i < 4; i++) wait_done();
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    repeat (2) @(negedge Clk);

    // Req1 raised while a Req0 frame is busy waits for the IDLE cycle.
    push_exp(1'b0, 8'hAA, 0, 1'b1);
    push_exp(1'b1, 8'h07, 2, 1'b1);
    bus.Req0  = 1'b1;
    bus.Data0 = 8'hAA;
    wait_gnt(1'b0);
    bus.Req0 = 1'b0;
    repeat (3) @(negedge Clk);
    chk("busy_mid_frame", int'(bus.Busy), 1);
    bus.Req1  = 1'b1;
    bus.Data1 = 8'h07;
    wait_gnt(1'b1);
    bus.Req1 = 1'b0;
    wait_done();

    repeat (4) @(negedge Clk);
    chk("left_gnt_q", gnt_q.size(), 0);
    chk("left_exp_q", exp_q.size(), 0);
    chk("left_data_q", data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
